// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchronizes and deglitches raw I2C SCL/SDA and flags SCL edges, START/STOP and bus busy.
// Define I2C_LINE_FILTER_GLITCH_CNT_EN to enable the saturating rejected-glitch counter on glitch_cnt_o.
module i2c_line_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       scl_pad_i,
    input  logic       sda_pad_i,
    output logic       scl_o,
    output logic       sda_o,
    output logic       scl_rise_o,
    output logic       scl_fall_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       busy_o,
    output logic [7:0] glitch_cnt_o
);
    localparam logic [3:0] FC = 4'(FILTER_CYCLES);
    // bit 0 carries SCL, bit 1 carries SDA throughout
    logic [1:0] pad, s1, s2, f, f_nxt;
    logic [3:0] cnt [2];
    assign pad   = {sda_pad_i, scl_pad_i};
    assign scl_o = f[0];
    assign sda_o = f[1];
    always_comb begin
        f_nxt = f;
        for (int i = 0; i < 2; i++)
            f_nxt[i] = (s2[i] != f[i] && cnt[i] + 4'd1 == FC) ? s2[i] : f[i];
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            s1     <= 2'b11;
            s2     <= 2'b11;
            f      <= 2'b11;
            cnt[0] <= 4'd0;
            cnt[1] <= 4'd0;
        end else begin
            s1 <= pad;
            s2 <= s1;
            f  <= f_nxt;
            for (int i = 0; i < 2; i++)
                cnt[i] <= (s2[i] == f[i] || f_nxt[i] != f[i]) ? 4'd0 : cnt[i] + 4'd1;
        end
    end
    // events are registered alongside the filtered lines so they coincide with the new scl_o/sda_o
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            scl_rise_o <= 1'b0;
            scl_fall_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            scl_rise_o <= ~f[0] & f_nxt[0];
            scl_fall_o <= f[0] & ~f_nxt[0];
            start_o    <= f[0] & f_nxt[0] & f[1] & ~f_nxt[1];
            stop_o     <= f[0] & f_nxt[0] & ~f[1] & f_nxt[1];
            busy_o     <= start_o | (busy_o & ~stop_o);
        end
    end
`ifdef I2C_LINE_FILTER_GLITCH_CNT_EN
    logic [1:0] rej;
    logic [8:0] gsum;
    always_comb begin
        rej = 2'b00;
        for (int i = 0; i < 2; i++)
            rej[i] = s2[i] == f[i] && cnt[i] != 4'd0;
        gsum = {1'b0, glitch_cnt_o} + 9'(rej[0]) + 9'(rej[1]);
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            glitch_cnt_o <= 8'h00;
        else
            glitch_cnt_o <= gsum[8] ? 8'hff : gsum[7:0];
    end
`else
    assign glitch_cnt_o = 8'h00;
`endif
endmodule
